// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared FSM encoding and segment pattern constants for the bus scanner
package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Segment order is bit0=a .. bit6=g, matching the forward encoder
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h67;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BCD_NONE  = 4'hF;

endpackage

// File: rtl/seg_to_bcd.sv
// rtl/seg_to_bcd.sv - combinational inverse of the 7-segment encoder
module seg_to_bcd
    import seg_scan_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_bcd,
    output logic       o_valid,
    output logic       o_err
);

    always_comb begin
        o_bcd   = BCD_NONE;
        o_valid = 1'b1;
        o_err   = 1'b0;
        case (i_seg)
            SEG_0:     o_bcd = 4'd0;
            SEG_1:     o_bcd = 4'd1;
            SEG_2:     o_bcd = 4'd2;
            SEG_3:     o_bcd = 4'd3;
            SEG_4:     o_bcd = 4'd4;
            SEG_5:     o_bcd = 4'd5;
            SEG_6:     o_bcd = 4'd6;
            SEG_7:     o_bcd = 4'd7;
            SEG_8:     o_bcd = 4'd8;
            SEG_9:     o_bcd = 4'd9;
            SEG_BLANK: o_valid = 1'b0;
            default: begin
                o_valid = 1'b0;
                o_err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_bcd_dec.sv
// rtl/seg_scan_bcd_dec.sv - samples a multiplexed 8-digit 7-segment bus and rebuilds per-digit BCD
// Optional macro SEG_DP_EN: decimal points are captured and take part in the settle compare.
module seg_scan_bcd_dec
    import seg_scan_pkg::*;
#(
    parameter int STABLE_CYC = 4,
    parameter int NUM_DIG    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           seg_data,
    input  logic [NUM_DIG-1:0]   seg_com,
    output logic [4*NUM_DIG-1:0] dig_bcd,
    output logic [NUM_DIG-1:0]   dig_valid,
    output logic [NUM_DIG-1:0]   dig_err,
    output logic [NUM_DIG-1:0]   dp_out,
    output logic                 frame_done,
    output logic                 com_err
);

    localparam int         IDX_W    = $clog2(NUM_DIG);
    localparam int         HIT_W    = $clog2(NUM_DIG + 1);
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYC - 1);

    logic [7:0]           w_data_in;
    logic [7:0]           r_cur_data, r_prev_data;
    logic [NUM_DIG-1:0]   r_cur_com, r_prev_com;
    state_t               r_state, w_state_next;
    logic [7:0]           r_cnt, w_cnt_next;
    logic                 w_same, w_eval, w_capture, w_com_bad, w_seen_full;
    logic [NUM_DIG-1:0]   w_com_n, w_seen_upd;
    logic [IDX_W-1:0]     w_idx;
    logic [HIT_W-1:0]     w_hits;
    logic [3:0]           w_bcd;
    logic                 w_valid, w_err;
    logic [4*NUM_DIG-1:0] r_bcd;
    logic [NUM_DIG-1:0]   r_valid, r_err, r_seen;
    logic                 r_fill, r_frame_done, r_com_err;

    // Without DP support bit7 is zeroed here so DP toggling cannot disturb settling
`ifdef SEG_DP_EN
    assign w_data_in = seg_data;
`else
    logic w_dp_unused;
    assign w_dp_unused = seg_data[7];
    assign w_data_in   = {1'b0, seg_data[6:0]};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cur_data  <= 8'h00;
            r_cur_com   <= '1;
            r_prev_data <= 8'h00;
            r_prev_com  <= '1;
        end else begin
            r_cur_data  <= w_data_in;
            r_cur_com   <= seg_com;
            r_prev_data <= r_cur_data;
            r_prev_com  <= r_cur_com;
        end
    end

    assign w_same = (r_cur_data == r_prev_data) && (r_cur_com == r_prev_com);
    assign w_eval = (r_state == ST_SETTLE) && w_same && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_SETTLE;
                w_cnt_next   = 8'd0;
            end
            ST_SETTLE: begin
                if (!w_same) begin
                    w_cnt_next = 8'd0;
                end else if (w_eval) begin
                    w_state_next = ST_HOLD;
                    w_cnt_next   = 8'd0;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            ST_HOLD: begin
                if (!w_same) begin
                    w_state_next = ST_SETTLE;
                    w_cnt_next   = 8'd0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = 8'd0;
            end
        endcase
    end

    // Zero low commons means an all-off bus; exactly one is a digit select
    assign w_com_n = ~r_cur_com;
    always_comb begin
        w_idx  = '0;
        w_hits = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (w_com_n[i]) begin
                w_idx  = IDX_W'(i);
                w_hits = w_hits + HIT_W'(1);
            end
        end
    end

    seg_to_bcd u_dec (
        .i_seg   (r_cur_data[6:0]),
        .o_bcd   (w_bcd),
        .o_valid (w_valid),
        .o_err   (w_err)
    );

    assign w_capture   = w_eval && (w_hits == HIT_W'(1));
    assign w_com_bad   = w_eval && (w_hits != HIT_W'(1)) && (w_hits != '0);
    assign w_seen_upd  = r_seen | (NUM_DIG'(1) << w_idx);
    assign w_seen_full = (w_seen_upd == '1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bcd        <= '1;
            r_valid      <= '0;
            r_err        <= '0;
            r_seen       <= '0;
            r_fill       <= 1'b0;
            r_frame_done <= 1'b0;
            r_com_err    <= 1'b0;
        end else begin
            r_fill       <= w_capture && w_seen_full;
            r_frame_done <= r_fill;
            r_com_err    <= w_com_bad;
            if (w_capture) begin
                r_bcd[4*w_idx +: 4] <= w_bcd;
                r_valid[w_idx]      <= w_valid;
                r_err[w_idx]        <= w_err;
                r_seen              <= w_seen_full ? '0 : w_seen_upd;
            end
        end
    end

`ifdef SEG_DP_EN
    logic [NUM_DIG-1:0] r_dp;
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dp <= '0;
        end else if (w_capture) begin
            r_dp[w_idx] <= r_cur_data[7];
        end
    end
    assign dp_out = r_dp;
`else
    assign dp_out = '0;
`endif

    assign dig_bcd    = r_bcd;
    assign dig_valid  = r_valid;
    assign dig_err    = r_err;
    assign frame_done = r_frame_done;
    assign com_err    = r_com_err;

endmodule

// File: tb/tb_seg_scan_bcd_dec.sv
// tb/tb_seg_scan_bcd_dec.sv - directed table-driven bench for seg_scan_bcd_dec
module tb_seg_scan_bcd_dec;

    localparam int STABLE_CYC = 4;
`ifdef SEG_DP_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    typedef struct {
        int         dig;
        logic [7:0] data;
        logic [3:0] bcd;
        logic       v;
        logic       e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  seg_data = 8'h00;
    logic [7:0]  seg_com = 8'hFF;
    logic [31:0] dig_bcd;
    logic [7:0]  dig_valid, dig_err, dp_out;
    logic        frame_done, com_err;

    int n_cmp = 0;
    int n_bad = 0;
    int fd_cnt = 0;
    int ce_cnt = 0;

    logic [31:0] m_bcd;
    logic [7:0]  m_valid, m_err, m_dp;
    vec_t        tbl [14];

    seg_scan_bcd_dec #(.STABLE_CYC(STABLE_CYC), .NUM_DIG(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_data   (seg_data),
        .seg_com    (seg_com),
        .dig_bcd    (dig_bcd),
        .dig_valid  (dig_valid),
        .dig_err    (dig_err),
        .dp_out     (dp_out),
        .frame_done (frame_done),
        .com_err    (com_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (frame_done) fd_cnt++;
        if (com_err) ce_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_bcd"}, dig_bcd, m_bcd);
        chk({tag, "_valid"}, {24'h0, dig_valid}, {24'h0, m_valid});
        chk({tag, "_err"}, {24'h0, dig_err}, {24'h0, m_err});
        chk({tag, "_dp"}, {24'h0, dp_out}, {24'h0, m_dp});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_bcd"}, dig_bcd, 32'hFFFF_FFFF);
        chk({tag, "_valid"}, {24'h0, dig_valid}, 32'h0);
        chk({tag, "_err"}, {24'h0, dig_err}, 32'h0);
        chk({tag, "_dp"}, {24'h0, dp_out}, 32'h0);
        chk({tag, "_fd"}, {31'h0, frame_done}, 32'h0);
        chk({tag, "_ce"}, {31'h0, com_err}, 32'h0);
    endtask

    function automatic logic [7:0] com_of(input int d);
        logic [7:0] c;
        c = 8'hFF;
        c[d] = 1'b0;
        return c;
    endfunction

    task automatic drive(input logic [7:0] com, input logic [7:0] data, input int n);
        seg_com  = com;
        seg_data = data;
        repeat (n) @(negedge clk);
    endtask

    task automatic model_set(input int d, input logic [7:0] data, input logic [3:0] bcd,
                             input logic v, input logic e);
        m_bcd[4*d +: 4] = bcd;
        m_valid[d]      = v;
        m_err[d]        = e;
        m_dp[d]         = DP_EN ? data[7] : 1'b0;
    endtask

    initial begin
        int fd0, ce0;

        tbl[0]  = '{0, 8'h3F, 4'h0, 1'b1, 1'b0};
        tbl[1]  = '{1, 8'h06, 4'h1, 1'b1, 1'b0};
        tbl[2]  = '{2, 8'h5B, 4'h2, 1'b1, 1'b0};
        tbl[3]  = '{3, 8'h4F, 4'h3, 1'b1, 1'b0};
        tbl[4]  = '{4, 8'h66, 4'h4, 1'b1, 1'b0};
        tbl[5]  = '{5, 8'h6D, 4'h5, 1'b1, 1'b0};
        tbl[6]  = '{6, 8'h7D, 4'h6, 1'b1, 1'b0};
        tbl[7]  = '{7, 8'h07, 4'h7, 1'b1, 1'b0};
        tbl[8]  = '{1, 8'h49, 4'hF, 1'b0, 1'b1};
        tbl[9]  = '{1, 8'h00, 4'hF, 1'b0, 1'b0};
        tbl[10] = '{0, 8'h7F, 4'h8, 1'b1, 1'b0};
        tbl[11] = '{5, 8'h67, 4'h9, 1'b1, 1'b0};
        tbl[12] = '{3, 8'hBF, 4'h0, 1'b1, 1'b0};
        tbl[13] = '{7, 8'h7E, 4'hF, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk_reset("reset");

        // First capture lands exactly on edge STABLE_CYC+2 after release
        rst = 1'b1;
        drive(8'hFE, 8'h5B, STABLE_CYC + 1);
        chk("early_bcd", dig_bcd, 32'hFFFF_FFFF);
        chk("early_valid", {24'h0, dig_valid}, 32'h0);
        drive(8'hFE, 8'h5B, 1);
        chk("first_bcd", dig_bcd, 32'hFFFF_FFF2);
        chk("first_valid", {24'h0, dig_valid}, 32'h1);

        m_bcd = 32'hFFFF_FFF2;
        m_valid = 8'h01;
        m_err = 8'h00;
        m_dp = 8'h00;
        fd0 = fd_cnt;

        for (int i = 0; i < 14; i++) begin
            drive(com_of(tbl[i].dig), tbl[i].data, 8);
            model_set(tbl[i].dig, tbl[i].data, tbl[i].bcd, tbl[i].v, tbl[i].e);
            chk_all($sformatf("vec%0d", i));
            if (i == 6) chk("fd_early", fd_cnt - fd0, 0);
            if (i == 7) begin
                chk("scan_bcd", dig_bcd, 32'h7654_3210);
                chk("scan_valid", {24'h0, dig_valid}, 32'hFF);
                chk("fd_once", fd_cnt - fd0, 1);
            end
        end

        ce0 = ce_cnt;
        drive(8'hFC, 8'h06, 8);
        chk("com_err_once", ce_cnt - ce0, 1);
        chk_all("com_err_nochg");
        drive(8'hFF, 8'h06, 8);
        chk("ff_no_pulse", ce_cnt - ce0, 1);
        chk_all("ff_nochg");

        // Dwell of STABLE_CYC cycles aborts; STABLE_CYC+1 captures
        drive(com_of(2), 8'h67, STABLE_CYC);
        drive(8'hFF, 8'h00, 8);
        chk_all("dwell_short");
        drive(com_of(2), 8'h67, STABLE_CYC + 1);
        drive(8'hFF, 8'h00, 3);
        model_set(2, 8'h67, 4'h9, 1'b1, 1'b0);
        chk_all("dwell_min");

        ce0 = ce_cnt;
        for (int k = 0; k < 6; k++) drive(com_of(4), (k % 2) ? 8'h5B : 8'h06, 3);
        chk_all("toggle_nocap");
        chk("toggle_no_ce", ce_cnt - ce0, 0);

        drive(com_of(6), 8'h7D, 3);
        rst = 1'b0;
        @(negedge clk);
        chk_reset("midrst");
        @(negedge clk);
        m_bcd = 32'hFFFF_FFFF;
        m_valid = 8'h00;
        m_err = 8'h00;
        m_dp = 8'h00;

        // A seen mask surviving reset would complete a frame on these three digits
        rst = 1'b1;
        fd0 = fd_cnt;
        drive(com_of(2), 8'h5B, 8);
        model_set(2, 8'h5B, 4'h2, 1'b1, 1'b0);
        drive(com_of(4), 8'h66, 8);
        model_set(4, 8'h66, 4'h4, 1'b1, 1'b0);
        drive(com_of(6), 8'h7D, 8);
        model_set(6, 8'h7D, 4'h6, 1'b1, 1'b0);
        drive(8'hFF, 8'h00, 4);
        chk_all("post_rst");
        chk("seen_lost", fd_cnt - fd0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_bcd_dec.md
# seg_scan_bcd_dec

Reverse-direction partner of the board's BCD-to-7-segment path: samples a multiplexed 8-digit seven-segment bus (`seg_data` and `seg_com`) and reconstructs each digit as BCD.
- Waits for the bus to settle, then decodes the active digit's segment pattern back to a 0-9 value.
- Keeps per-digit valid, error and decimal-point flags, and marks completed scan frames.
- Sits on the display side of the top level; serves self-check logic and lab test benches that confirm what the display actually shows.

## Interface
- `STABLE_CYC`, default 4: consecutive cycles the bus must hold unchanged before capture; legal range 2-255.
- `NUM_DIG`, default 8: number of digit positions scanned; fixed at 8 for this board.
- `clk` in 1: single clock; every register is on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `seg_data` in 8: segment lines, active-high; bit0=a … bit6=g, bit7=dp.
- `seg_com` in 8: digit commons, active-low; exactly one bit low selects a digit (bit i = digit i).
- `dig_bcd` out 32: digit i at [4i+3:4i]; 4'hF = blank or unknown.
- `dig_valid` out 8: bit i set when digit i holds a recognized 0-9 pattern.
- `dig_err` out 8: bit i set when digit i's last capture was a non-blank, unrecognized pattern.
- `dp_out` out 8: decimal point of digit i.
- `frame_done` out 1: one-cycle pulse after all 8 digits have been captured since the last pulse or reset.
- `com_err` out 1: one-cycle pulse when a settled `seg_com` value is neither one-hot-low nor 8'hFF.

## Operation
- Both buses are registered once into `s_cur`; `s_prev` holds the previous `s_cur`.
- FSM states:
  - IDLE: entered from reset; moves to SETTLE next cycle.
  - SETTLE: `cnt` increments while `s_cur == s_prev` and clears to 0 on any difference. When `cnt == STABLE_CYC-1`, the block evaluates `seg_com` and moves to HOLD.
  - HOLD: no further capture; any change in `s_cur` returns to SETTLE with `cnt=0`.
- Evaluation at the end of SETTLE:
  - One-hot-low `seg_com`, digit i: capture digit i.
  - 8'hFF: no action.
  - Any other value: pulse `com_err`; no capture.
- Decode uses `seg_data[6:0]`, the exact inverse of the encoder patterns:
  - 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x67=9.
  - 0x00 (blank): bcd=F, valid=0, err=0.
  - Any other pattern: bcd=F, valid=0, err=1.
- A capture of digit i overwrites only that digit's bcd, valid, err and dp fields.
- A `seen` mask sets bit i on each capture. When a capture fills the mask, the mask clears and `frame_done` pulses the following cycle. Recapturing an already-seen digit changes nothing in the mask.
- Reset values: `dig_bcd`=32'hFFFF_FFFF; `dig_valid`, `dig_err`, `dp_out`=0; `frame_done`, `com_err`=0; `seen`=0; `cnt`=0; state=IDLE.

## Timing
- Capture latency: digit outputs update on the (STABLE_CYC+2)th rising edge after both pin buses settle. That is 1 edge for the input register plus STABLE_CYC edges of stability plus 1 edge for the capture register.
- `frame_done` and `com_err` are registered pulses, exactly 1 cycle wide.
- `frame_done` rises one cycle after the capture that completes the mask.
- A bus change on the cycle `cnt` would reach STABLE_CYC-1 aborts the capture.
- A reset asserted at any point clears all state on that edge. A capture in flight is discarded and the partial `seen` mask is lost.
- Scan dwell shorter than STABLE_CYC+1 cycles per digit never captures. This is required behaviour, not an error.

## Configuration
- `SEG_DP_EN` defined:
  - bit7 takes part in the stability compare.
  - `dp_out[i]` is loaded from bit7 on each capture of digit i.
- `SEG_DP_EN` undefined:
  - bit7 is forced to 0 before the input register, so DP toggling never restarts settling.
  - `dp_out` is constant 8'h00.

## Structure
- Package `seg_scan_pkg` holds:
  - FSM state encoding (IDLE, SETTLE, HOLD).
  - Pattern constants `SEG_0`…`SEG_9`, `SEG_BLANK`.
  - `BCD_NONE`=4'hF.
- Sub-module `seg_to_bcd`: combinational, 7-bit pattern in; 4-bit bcd, `valid` and `err` out. It is instantiated once, on `s_cur`.

## Test plan
- Reset, then hold `seg_com`=8'hFE, `seg_data`=0x5B for 6 cycles → `dig_bcd[3:0]`=2 and `dig_valid[0]`=1 on edge STABLE_CYC+2; all other digits stay F.
- Scan digits 0-7 with patterns 0-7, 8 cycles each → `dig_bcd`=32'h7654_3210, `dig_valid`=8'hFF, a single `frame_done` pulse after digit 7; no `frame_done` while looping digits 0-6.
- `seg_com`=8'hFD with `seg_data`=0x49 → `dig_err[1]`=1, `dig_valid[1]`=0, `dig_bcd[7:4]`=F. Then 0x00 → err clears, valid stays 0.
- `seg_com`=8'hFC for 8 cycles → one `com_err` pulse and no digit change. `seg_com`=8'hFF → no pulse.
- Toggle `seg_data` every 3 cycles with `STABLE_CYC`=4 → no capture. Assert `rst` low mid-scan → all outputs return to reset values on the next edge.
- With `SEG_DP_EN`: `seg_data`=0xBF on digit 3 → `dp_out[3]`=1, `dig_bcd[15:12]`=0. Without the macro, same stimulus → `dp_out`=0, bcd=0.
